// File: rtl/fir_sample_packer.sv
// rtl/fir_sample_packer.sv - packs a byte stream into 32-bit FIR samples behind a small word FIFO
//
// Ports:
//   clk       sole clock, rising edge
//   rst       synchronous active-high reset
//   byte_in   input sample byte
//   byte_vld  byte_in valid, one byte consumed per asserted cycle
//   sync      drop any partial word and restart assembly at byte 0
//   word_out  FIFO head word (holds last value while FIFO empty)
//   word_vld  word_out valid, equals (level != 0)
//   word_rdy  consumer accepts word_out this cycle
//   level     number of FIFO entries occupied
//   overflow  sticky: a completed word was dropped on a full FIFO
//   partial   at least one byte of the current word is held
module fir_sample_packer #(
  parameter int BIG_ENDIAN = 0,
  parameter int DEPTH      = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               byte_in,
  input  logic                     byte_vld,
  input  logic                     sync,
  output logic [31:0]              word_out,
  output logic                     word_vld,
  input  logic                     word_rdy,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     partial
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [1:0]    cnt;
  logic [31:0]   asm_q;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level_q;
  logic          overflow_q;
  logic [31:0]   hold_q;

  logic [1:0]    cnt_eff;
  logic [1:0]    lane;
  logic [31:0]   asm_next;
  logic          push;
  logic          pop;
  logic          full;
  logic          push_ok;

  // sync acts in the same cycle: the current byte (if any) lands as byte 0
  // on a cleared word, so the counter and base word are muxed before use.
  // The completed word is taken from asm_next so the 4th byte costs no cycle.
  always_comb begin
    cnt_eff  = sync ? 2'd0 : cnt;
    asm_next = sync ? 32'd0 : asm_q;
    lane     = (BIG_ENDIAN != 0) ? (2'd3 - cnt_eff) : cnt_eff;
    if (byte_vld) begin
      asm_next[{lane, 3'b000} +: 8] = byte_in;
    end
    push    = byte_vld && (cnt_eff == 2'd3);
    full    = (level_q == LW'(DEPTH));
    pop     = word_vld && word_rdy;
    // a pop frees the head slot in the same edge, so a push into a full FIFO
    // is still accepted when the consumer is taking a word
    push_ok = push && (!full || pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= 2'd0;
      asm_q      <= 32'd0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      hold_q     <= 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 32'd0;
      end
    end else begin
      cnt   <= byte_vld ? (cnt_eff + 2'd1) : cnt_eff;
      asm_q <= push ? 32'd0 : asm_next;

      if (push_ok) begin
        mem[wr_ptr] <= asm_next;
        wr_ptr      <= wr_ptr + AW'(1);
      end

      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        // remember the word being handed out so word_out holds it once empty
        hold_q <= mem[rd_ptr];
      end

      case ({push_ok, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase

      if (push && !push_ok) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign word_vld = (level_q != '0);
  assign word_out = word_vld ? mem[rd_ptr] : hold_q;
  assign level    = level_q;
  assign overflow = overflow_q;
  assign partial  = (cnt != 2'd0);

endmodule

// File: tb/tb_fir_sample_packer.sv
// tb/tb_fir_sample_packer.sv - self-checking bench for fir_sample_packer
module tb_fir_sample_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  byte_in;
  logic        byte_vld;
  logic        sync;
  logic        word_rdy;

  logic [31:0] word_out_le, word_out_be;
  logic        word_vld_le, word_vld_be;
  logic [1:0]  level_le, level_be;
  logic        overflow_le, overflow_be;
  logic        partial_le, partial_be;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fir_sample_packer #(.BIG_ENDIAN(0), .DEPTH(2)) dut_le (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_vld(byte_vld), .sync(sync),
    .word_out(word_out_le), .word_vld(word_vld_le), .word_rdy(word_rdy),
    .level(level_le), .overflow(overflow_le), .partial(partial_le)
  );

  fir_sample_packer #(.BIG_ENDIAN(1), .DEPTH(2)) dut_be (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_vld(byte_vld), .sync(sync),
    .word_out(word_out_be), .word_vld(word_vld_be), .word_rdy(word_rdy),
    .level(level_be), .overflow(overflow_be), .partial(partial_be)
  );

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] exp_le;
    logic [31:0] exp_be;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // advance one edge; inputs change and outputs are sampled 1ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_in  = b;
    byte_vld = 1'b1;
    tick();
    byte_vld = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " word_out_le"}, word_out_le, 32'h0);
    check({tag, " word_vld_le"}, {31'd0, word_vld_le}, 32'd0);
    check({tag, " level_le"},    {30'd0, level_le}, 32'd0);
    check({tag, " overflow_le"}, {31'd0, overflow_le}, 32'd0);
    check({tag, " partial_le"},  {31'd0, partial_le}, 32'd0);
    check({tag, " word_out_be"}, word_out_be, 32'h0);
    check({tag, " level_be"},    {30'd0, level_be}, 32'd0);
    check({tag, " partial_be"},  {31'd0, partial_be}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{b0:8'h11, b1:8'h22, b2:8'h33, b3:8'h44, exp_le:32'h44332211, exp_be:32'h11223344};
    vecs[1] = '{b0:8'h00, b1:8'hFF, b2:8'h00, b3:8'hFF, exp_le:32'hFF00FF00, exp_be:32'h00FF00FF};
    vecs[2] = '{b0:8'hDE, b1:8'hAD, b2:8'hBE, b3:8'hEF, exp_le:32'hEFBEADDE, exp_be:32'hDEADBEEF};
    vecs[3] = '{b0:8'h01, b1:8'h80, b2:8'h7F, b3:8'hFE, exp_le:32'hFE7F8001, exp_be:32'h01807FFE};
    vecs[4] = '{b0:8'hA5, b1:8'h5A, b2:8'hC3, b3:8'h3C, exp_le:32'h3CC35AA5, exp_be:32'hA55AC33C};

    rst = 1'b1; byte_in = 8'h00; byte_vld = 1'b0; sync = 1'b0; word_rdy = 1'b0;
    #2;
    do_reset();
    check_reset_state("reset");

    // back-to-back bytes, consumer always ready: word visible exactly one cycle
    word_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      byte_vld = 1'b1;
      byte_in = vecs[i].b0; tick();
      check($sformatf("v%0d partial after b0", i), {31'd0, partial_le}, 32'd1);
      byte_in = vecs[i].b1; tick();
      byte_in = vecs[i].b2; tick();
      check($sformatf("v%0d no word before b3", i), {31'd0, word_vld_le}, 32'd0);
      byte_in = vecs[i].b3; tick();
      byte_vld = 1'b0;
      check($sformatf("v%0d word_vld_le", i), {31'd0, word_vld_le}, 32'd1);
      check($sformatf("v%0d word_out_le", i), word_out_le, vecs[i].exp_le);
      check($sformatf("v%0d word_out_be", i), word_out_be, vecs[i].exp_be);
      check($sformatf("v%0d partial after b3", i), {31'd0, partial_le}, 32'd0);
      tick();
      check($sformatf("v%0d word_vld drops", i), {31'd0, word_vld_le}, 32'd0);
      check($sformatf("v%0d word_out holds", i), word_out_le, vecs[i].exp_le);
    end

    // big-endian with two idle cycles between bytes; partial must persist
    send_byte(8'h11);
    check("gap partial b1", {31'd0, partial_be}, 32'd1);
    tick(); tick();
    check("gap partial idle", {31'd0, partial_be}, 32'd1);
    send_byte(8'h22); tick(); tick();
    send_byte(8'h33); tick(); tick();
    check("gap partial b3", {31'd0, partial_be}, 32'd1);
    check("gap no early word", {31'd0, word_vld_be}, 32'd0);
    send_byte(8'h44);
    check("gap partial cleared", {31'd0, partial_be}, 32'd0);
    check("gap word_vld_be", {31'd0, word_vld_be}, 32'd1);
    check("gap word_out_be", word_out_be, 32'h11223344);
    tick();

    // sync with a byte in the same cycle restarts at byte 0
    word_rdy = 1'b0;
    send_byte(8'hAA);
    send_byte(8'hBB);
    sync = 1'b1;
    send_byte(8'h01);
    sync = 1'b0;
    check("sync partial", {31'd0, partial_le}, 32'd1);
    send_byte(8'h02);
    send_byte(8'h03);
    check("sync no stray word", {30'd0, level_le}, 32'd0);
    send_byte(8'h04);
    check("sync level", {30'd0, level_le}, 32'd1);
    check("sync word_le", word_out_le, 32'h04030201);
    check("sync word_be", word_out_be, 32'h01020304);
    // sync alone drops the partial word without touching the FIFO
    send_byte(8'h99);
    sync = 1'b1; tick(); sync = 1'b0;
    check("sync alone partial", {31'd0, partial_le}, 32'd0);
    check("sync alone level", {30'd0, level_le}, 32'd1);
    word_rdy = 1'b1; tick(); word_rdy = 1'b0;
    check("sync drained", {30'd0, level_le}, 32'd0);

    // overflow: three words into a two-entry FIFO with no consumer
    do_reset();
    for (int w = 0; w < 3; w++) begin
      for (int k = 0; k < 4; k++) send_byte(8'(w * 8'h11));
    end
    check("ovf level", {30'd0, level_le}, 32'd2);
    check("ovf flag", {31'd0, overflow_le}, 32'd1);
    check("ovf head", word_out_le, 32'h00000000);
    word_rdy = 1'b1;
    tick();
    check("ovf second", word_out_le, 32'h11111111);
    check("ovf level 1", {30'd0, level_le}, 32'd1);
    tick();
    check("ovf empty", {30'd0, level_le}, 32'd0);
    check("ovf no third", {31'd0, word_vld_le}, 32'd0);
    check("ovf hold", word_out_le, 32'h11111111);
    check("ovf sticky", {31'd0, overflow_le}, 32'd1);
    tick();
    check("ovf rdy while empty", {30'd0, level_le}, 32'd0);
    word_rdy = 1'b0;

    // full FIFO, completing byte coincides with a pop
    do_reset();
    check("ovf cleared by rst", {31'd0, overflow_le}, 32'd0);
    send_byte(8'h10); send_byte(8'h20); send_byte(8'h30); send_byte(8'h40);
    send_byte(8'h50); send_byte(8'h60); send_byte(8'h70); send_byte(8'h80);
    send_byte(8'h90); send_byte(8'hA0); send_byte(8'hB0);
    check("full level", {30'd0, level_le}, 32'd2);
    check("full head stable", word_out_le, 32'h40302010);
    word_rdy = 1'b1;
    send_byte(8'hC0);
    word_rdy = 1'b0;
    check("pushpop level", {30'd0, level_le}, 32'd2);
    check("pushpop overflow", {31'd0, overflow_le}, 32'd0);
    check("pushpop head", word_out_le, 32'h80706050);
    word_rdy = 1'b1;
    tick();
    check("pushpop last", word_out_le, 32'hC0B0A090);
    check("pushpop last be", word_out_be, 32'h90A0B0C0);
    tick();
    check("pushpop drained", {30'd0, level_le}, 32'd0);
    word_rdy = 1'b0;

    // reset mid-word with a non-empty FIFO; inputs active during reset are ignored
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h55); send_byte(8'h66);
    check("pre-rst level", {30'd0, level_le}, 32'd1);
    check("pre-rst partial", {31'd0, partial_le}, 32'd1);
    rst = 1'b1; byte_vld = 1'b1; byte_in = 8'h77; sync = 1'b1; word_rdy = 1'b1;
    tick();
    rst = 1'b0; byte_vld = 1'b0; sync = 1'b0; word_rdy = 1'b0;
    check_reset_state("midrst");
    send_byte(8'h0A); send_byte(8'h0B); send_byte(8'h0C); send_byte(8'h0D);
    check("post-rst level", {30'd0, level_le}, 32'd1);
    check("post-rst word_le", word_out_le, 32'h0D0C0B0A);
    check("post-rst word_be", word_out_be, 32'h0A0B0C0D);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
